// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART bridge RTL.
//   uart_state_t : IDLE/START/DATA/STOP, used by both the RX and TX FSMs.
//   DATA_BITS    : payload bits per frame (8N1).
//   LINE_IDLE    : resting level of an idle UART line.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous show-ahead byte FIFO.
//   clock, reset    : rising-edge clock, synchronous active-low reset.
//   push_i, data_i  : write strobe and byte; dropped when full unless a pop
//                     frees a slot in the same cycle.
//   pop_i           : advance the head; ignored when empty.
//   data_o          : current head byte, 8'h00 while empty.
//   full_o, empty_o : status decoded from the pointer pair.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // addresses with differing wrap bits mean full.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign data_o  = empty_o ? 8'h00 : mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_serial_bridge.sv
// uart_serial_bridge: 8N1 UART bridge between the processor's memory-mapped
// serial ports and the board UART pins.
//   clock, reset         : rising-edge clock, synchronous active-low reset.
//   uart_rxd / uart_txd  : serial line in (asynchronous) / out (registered).
//   proc_data_out        : RX FIFO head (show-ahead), 0 when empty.
//   proc_valid_out       : RX FIFO non-empty.
//   proc_ready_out       : TX FIFO not full.
//   proc_data_in/wren_in : byte pushed into the TX FIFO.
//   proc_rden_in         : pops the RX FIFO head.
//   rx_overrun_out       : sticky, set when a received byte hits a full FIFO.
// Build option: define UART_LOOPBACK_EN to feed the RX path from uart_txd
// instead of uart_rxd (board self-test).
module uart_serial_bridge
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic [7:0] proc_data_out,
    output logic       proc_valid_out,
    output logic       proc_ready_out,
    input  logic [7:0] proc_data_in,
    input  logic       proc_rden_in,
    input  logic       proc_wren_in,
    output logic       rx_overrun_out
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    BIT_IDX_LAST = 3'(DATA_BITS - 1);

    // ---------------- FIFOs ----------------
    logic       rx_push_q;
    logic [7:0] rx_byte_q;
    logic       rx_full;
    logic       rx_empty;
    logic       tx_pop;
    logic [7:0] tx_head;
    logic       tx_full;
    logic       tx_empty;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (rx_push_q),
        .data_i  (rx_byte_q),
        .pop_i   (proc_rden_in),
        .data_o  (proc_data_out),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (proc_wren_in),
        .data_i  (proc_data_in),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    assign proc_valid_out = !rx_empty;
    assign proc_ready_out = !tx_full;

    // ---------------- TX path ----------------
    uart_state_t   tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_shift_q;
    logic          txd_q;

    // The head is taken in the same cycle the FSM leaves IDLE.
    assign tx_pop   = (tx_state_q == IDLE) && !tx_empty;
    assign uart_txd = txd_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= LINE_IDLE;
        end else begin
            // Line level follows the state one cycle later, so every bit
            // still lasts exactly CLKS_PER_BIT cycles.
            case (tx_state_q)
                START:   txd_q <= 1'b0;
                DATA:    txd_q <= tx_shift_q[0];
                default: txd_q <= LINE_IDLE;
            endcase

            case (tx_state_q)
                IDLE: begin
                    tx_cnt_q <= '0;
                    if (!tx_empty) begin
                        tx_shift_q <= tx_head;
                        tx_state_q <= START;
                    end
                end
                START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_bit_q   <= tx_bit_q + 1'b1;
                        if (tx_bit_q == BIT_IDX_LAST) tx_state_q <= STOP;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    // ---------------- RX path ----------------
    logic rx_src;
`ifdef UART_LOOPBACK_EN
    logic unused_rxd;
    assign unused_rxd = uart_rxd;
    assign rx_src     = txd_q;
`else
    assign rx_src     = uart_rxd;
`endif

    logic          rx_meta_q;
    logic          rx_sync_q;
    uart_state_t   rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          overrun_q;

    assign rx_overrun_out = overrun_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta_q  <= LINE_IDLE;
            rx_sync_q  <= LINE_IDLE;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_push_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_meta_q <= rx_src;
            rx_sync_q <= rx_meta_q;
            rx_push_q <= 1'b0;

            // A full FIFO still accepts the push if the processor pops in
            // the same cycle, so only a push without a pop is an overrun.
            if (rx_push_q && rx_full && !proc_rden_in) overrun_q <= 1'b1;

            case (rx_state_q)
                IDLE: begin
                    rx_cnt_q <= '0;
                    if (!rx_sync_q) rx_state_q <= START;
                end
                START: begin
                    // Half a bit in: re-check so later samples land mid-bit.
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? IDLE : DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        if (rx_bit_q == BIT_IDX_LAST) rx_state_q <= STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= IDLE;
                        // Low stop bit is a framing error: byte discarded.
                        if (rx_sync_q) begin
                            rx_byte_q <= rx_shift_q;
                            rx_push_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_serial_bridge.md
# uart_serial_bridge

Byte-oriented UART bridge on the processor's serial I/O path, between the data memory's memory-mapped serial ports and the board UART pins. Deserialises received frames into an RX FIFO presented to the processor as serial_in/serial_valid_in. Accepts processor write strobes into a TX FIFO that is serialised onto the TX pin. Both directions are 8N1, LSB first.

## Interface
- CLKS_PER_BIT, 434: clock cycles per bit time (115200 baud at 50 MHz); must be ≥4.
- FIFO_DEPTH, 8: entries per FIFO; power of two, ≥2.
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  reset, synchronous, active-low.
- uart_rxd  in  1  asynchronous serial input; idles high.
- uart_txd  out  1  serial output; idles high.
- proc_data_out  out  8  RX FIFO head byte (show-ahead); drives processor serial_in.
- proc_valid_out  out  1  RX FIFO non-empty; drives serial_valid_in.
- proc_ready_out  out  1  TX FIFO not full; drives serial_ready_in.
- proc_data_in  in  8  byte to transmit; from processor serial_out.
- proc_rden_in  in  1  pops the RX head; from serial_rden_out.
- proc_wren_in  in  1  pushes proc_data_in; from serial_wren_out.
- rx_overrun_out  out  1  sticky flag; set when a received byte is dropped because the RX FIFO is full.

## Operation
- Each cycle with proc_rden_in=1 or proc_wren_in=1 is exactly one transaction. Strobes may be held for consecutive cycles.
- proc_rden_in while the RX FIFO is empty: ignored. proc_wren_in while the TX FIFO is full: byte dropped silently.
- proc_data_out = 8'h00 while the RX FIFO is empty.
- RX path:
  - uart_rxd passes through a 2-flop synchroniser.
  - FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a synchronised low.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If the line is high, treat it as a glitch and return to IDLE; otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample once at the stop-bit midpoint. High → push the byte, then IDLE. Low → framing error: discard the byte and return to IDLE.
- RX overrun: a push into a full RX FIFO drops the new byte and sets rx_overrun_out. The flag clears only on reset.
- TX path:
  - FSM states: IDLE, START, DATA, STOP.
  - IDLE with TX FIFO non-empty: pop the head into a shift register and go to START.
  - Each state lasts CLKS_PER_BIT cycles; DATA runs 8 bits, LSB first.
  - After STOP, return to IDLE. A back-to-back start bit may begin on the next cycle.
  - uart_txd is registered.
- Simultaneous push and pop on one FIFO:
  - Both take effect.
  - When full, the push is accepted because the pop frees a slot.
  - When empty, the pop is ignored and the push is accepted.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide. Full/empty is decoded from the MSB difference; pointers wrap naturally.

## Timing
- Reset values: uart_txd=1, proc_valid_out=0, proc_ready_out=1, proc_data_out=0, rx_overrun_out=0. Both FSMs in IDLE, both FIFOs empty, all counters 0.
- Reset asserted mid-frame aborts the frame. uart_txd is high the cycle after the reset edge, and any partial RX byte is lost.
- TX latency: proc_wren_in sampled at edge N with the TX path idle → uart_txd goes low (start bit) after edge N+2.
- RX latency: the stop-bit midpoint sample at edge M → proc_valid_out=1 and byte on proc_data_out after edge M+1.
- proc_rden_in at edge K → the next head byte (or valid=0) is visible after edge K.
- proc_ready_out falls in the cycle after the push that fills the FIFO.

## Configuration
- UART_LOOPBACK_EN defined: the RX synchroniser input is taken from internal uart_txd instead of uart_rxd, and uart_rxd is ignored. Used for board self-test.
- Undefined: normal operation, with RX fed from uart_rxd.

## Structure
- Package uart_pkg:
  - uart_state_t enum (IDLE, START, DATA, STOP), shared by both FSMs.
  - Constants for data bits (8) and the idle line level (1'b1).
- One sub-module, byte_fifo (parameter DEPTH):
  - Synchronous show-ahead FIFO with push/pop/full/empty.
  - Instantiated twice: RX and TX.

## Test plan
- Bench uses CLKS_PER_BIT=4, FIFO_DEPTH=8.
- Reset: hold reset=0 for 2 cycles → uart_txd=1, proc_valid_out=0, proc_ready_out=1, rx_overrun_out=0.
- TX frame: single proc_wren_in pulse with 8'h41 → uart_txd sequence 0,1,0,0,0,0,0,1,0,1, each bit exactly 4 cycles, start bit 2 edges after the strobe.
- RX frame: drive 8'hA5 as 8N1 on uart_rxd → proc_valid_out=1, proc_data_out=8'hA5; one proc_rden_in pulse → proc_valid_out=0, proc_data_out=0.
- Overrun: send 9 frames (8'h01..8'h09) without reading → 8'h01..8'h08 read back in order, 8'h09 absent, rx_overrun_out=1.
- Framing and glitch: frame 8'h33 with stop bit low → no byte pushed. A 1-cycle low pulse on idle uart_rxd → no byte pushed, RX FSM back in IDLE.
- Loopback (UART_LOOPBACK_EN defined): write 8'h3C → 8'h3C readable on proc_data_out within 45 cycles.
